// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared constants for the single-precision arithmetic cores (square, adder,
// divider): exponent bias and limits, special encodings, and the common state
// encoding of the operand/result handshake FSM.
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam logic signed [9:0] FP_BIAS  = 10'sd127;
    localparam logic signed [9:0] EXP_MIN  = -10'sd126;
    localparam logic signed [9:0] EXP_MAX  = 10'sd127;

    localparam logic [31:0] FP_PINF = 32'h7F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef logic [2:0] fp_state_t;

    localparam fp_state_t ST_GET_A   = 3'd0;
    localparam fp_state_t ST_UNPACK  = 3'd1;
    localparam fp_state_t ST_SPECIAL = 3'd2;
    localparam fp_state_t ST_MULT    = 3'd3;
    localparam fp_state_t ST_NORM    = 3'd4;
    localparam fp_state_t ST_ROUND   = 3'd5;
    localparam fp_state_t ST_PACK    = 3'd6;
    localparam fp_state_t ST_PUT_Z   = 3'd7;

endpackage

// File: rtl/fp_round_pack.sv
// -----------------------------------------------------------------------------
// fp_round_pack
// Combinational round-to-nearest-even and pack of a normalised result.
// Ports:
//   i_ez    signed unbiased exponent
//   i_mant  24b mantissa including hidden bit
//   i_g/i_r/i_s  guard, round, sticky bits below the mantissa lsb
//   o_z     packed IEEE-754 single; +Inf on overflow, +0 on underflow
// The sign bit is always 0 (a square is never negative).
// -----------------------------------------------------------------------------
module fp_round_pack
    import fp_pkg::*;
(
    input  logic signed [9:0]  i_ez,
    input  logic        [23:0] i_mant,
    input  logic               i_g,
    input  logic               i_r,
    input  logic               i_s,
    output logic        [31:0] o_z
);

    logic               w_inc;
    logic        [24:0] w_sum;
    logic signed [9:0]  w_ez;
    logic        [22:0] w_frac;
    logic        [7:0]  w_bexp;

    always_comb begin
        w_inc  = i_g & (i_r | i_s | i_mant[0]);
        w_sum  = {1'b0, i_mant} + {24'd0, w_inc};
        // Carry out of the mantissa means it was all ones: result is 2.0 * 2^ez.
        if (w_sum[24]) begin
            w_ez   = i_ez + 10'sd1;
            w_frac = 23'd0;
        end else begin
            w_ez   = i_ez;
            w_frac = w_sum[22:0];
        end
        // Only evaluated into the word when w_ez is in range, so 8 bits suffice.
        w_bexp = w_ez[7:0] + FP_BIAS[7:0];
        if (w_ez > EXP_MAX) begin
            o_z = FP_PINF;
        end else if (w_ez < EXP_MIN) begin
            o_z = FP_ZERO;
        end else begin
            o_z = {1'b0, w_bexp, w_frac};
        end
    end

endmodule

// File: rtl/fp_square.sv
// -----------------------------------------------------------------------------
// fp_square
// IEEE-754 single-precision squaring unit, z = a*a, one transaction at a time.
// Ports:
//   CLK2, RST (async, active-low)
//   input_a / input_a_stb / input_a_ack     operand handshake (responder)
//   output_z / output_z_stb / output_z_ack  result handshake
// Handshake: a word moves on a rising edge where stb and ack are both high;
// stb holds the word stable until then, and neither side may make stb depend
// on ack. A result is normally valid 6 edges after the accept edge, 2 edges
// for NaN/Inf/zero/denormal operands.
// -----------------------------------------------------------------------------
module fp_square
    import fp_pkg::*;
#(
    parameter logic [31:0] QNAN_VALUE = FP_QNAN
) (
    input  logic        CLK2,
    input  logic        RST,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    fp_state_t          r_state;
    fp_state_t          w_state_nxt;
    logic               r_a_ack;
    logic               r_z_stb;
    logic        [31:0] r_z;
    logic        [30:0] r_a;       // sign dropped: it never affects a square
    logic signed [9:0]  r_e;
    logic        [23:0] r_m;
    logic        [47:0] r_p;
    logic signed [9:0]  r_ez;
    logic        [23:0] r_nm;
    logic               r_g;
    logic               r_r;
    logic               r_s;
    logic        [31:0] r_res;

    logic               w_accept;
    logic               w_handshake;
    logic               w_exp_zero;
    logic               w_exp_max;
    logic               w_special;
    logic        [31:0] w_special_z;
    logic               w_a_ack_nxt;
    logic               w_z_stb_nxt;
    logic        [31:0] w_packed;

    assign input_a_ack  = r_a_ack;
    assign output_z_stb = r_z_stb;
    assign output_z     = r_z;

    assign w_accept    = (r_state == ST_GET_A) && input_a_stb && r_a_ack;
    assign w_handshake = (r_state == ST_PUT_Z) && output_z_ack;

    // Operand classification, used in SPECIAL.
    assign w_exp_zero  = (r_a[30:23] == 8'd0);
    assign w_exp_max   = (r_a[30:23] == 8'hFF);
    assign w_special   = w_exp_zero | w_exp_max;
    assign w_special_z = w_exp_zero        ? FP_ZERO    :
                         (|r_a[22:0])      ? QNAN_VALUE : FP_PINF;

    fp_round_pack u_round_pack (
        .i_ez   (r_ez),
        .i_mant (r_nm),
        .i_g    (r_g),
        .i_r    (r_r),
        .i_s    (r_s),
        .o_z    (w_packed)
    );

    // State register.
    always_ff @(posedge CLK2 or negedge RST) begin
        if (!RST) begin
            r_state <= ST_GET_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_GET_A:   if (w_accept) w_state_nxt = ST_UNPACK;
            ST_UNPACK:  w_state_nxt = ST_SPECIAL;
            ST_SPECIAL: w_state_nxt = w_special ? ST_PUT_Z : ST_MULT;
            ST_MULT:    w_state_nxt = ST_NORM;
            ST_NORM:    w_state_nxt = ST_ROUND;
            ST_ROUND:   w_state_nxt = ST_PACK;
            ST_PACK:    w_state_nxt = ST_PUT_Z;
            ST_PUT_Z:   if (w_handshake) w_state_nxt = ST_GET_A;
            default:    w_state_nxt = ST_GET_A;
        endcase
    end

    // Output logic: next values of the registered handshake outputs.
    // ack reopens on the handshake edge itself so the unit is ready the cycle
    // after a result is taken, never while the result is still offered.
    always_comb begin
        w_a_ack_nxt = ((r_state == ST_GET_A) && !w_accept) || w_handshake;
        w_z_stb_nxt = (w_state_nxt == ST_PUT_Z);
    end

    // Handshake outputs and datapath registers.
    always_ff @(posedge CLK2 or negedge RST) begin
        if (!RST) begin
            r_a_ack <= 1'b0;
            r_z_stb <= 1'b0;
            r_z     <= 32'd0;
            r_a     <= 31'd0;
            r_e     <= 10'sd0;
            r_m     <= 24'd0;
            r_p     <= 48'd0;
            r_ez    <= 10'sd0;
            r_nm    <= 24'd0;
            r_g     <= 1'b0;
            r_r     <= 1'b0;
            r_s     <= 1'b0;
            r_res   <= 32'd0;
        end else begin
            r_a_ack <= w_a_ack_nxt;
            r_z_stb <= w_z_stb_nxt;
            case (r_state)
                ST_GET_A: begin
                    if (w_accept) r_a <= input_a[30:0];
                end
                ST_UNPACK: begin
                    r_e <= $signed({2'b00, r_a[30:23]}) - FP_BIAS;
                    r_m <= {1'b1, r_a[22:0]};
                end
                ST_SPECIAL: begin
                    if (w_special) r_z <= w_special_z;
                end
                ST_MULT: begin
                    r_p  <= r_m * r_m;
                    r_ez <= r_e + r_e;
                end
                ST_NORM: begin
                    // p lies in [1,4): at most a one-place right normalisation.
                    if (r_p[47]) begin
                        r_ez <= r_ez + 10'sd1;
                        r_nm <= r_p[47:24];
                        r_g  <= r_p[23];
                        r_r  <= r_p[22];
                        r_s  <= |r_p[21:0];
                    end else begin
                        r_nm <= r_p[46:23];
                        r_g  <= r_p[22];
                        r_r  <= r_p[21];
                        r_s  <= |r_p[20:0];
                    end
                end
                ST_ROUND: r_res <= w_packed;
                ST_PACK:  r_z   <= r_res;
                default: ;
            endcase
        end
    end

endmodule
